// File: rtl/uart_tx_sched_if.sv
// uart_tx_sched_if: request/acknowledge bundle between the byte producers
// and the shared UART transmit scheduler.
//   req  : per-requester byte-valid, held high until the matching ack.
//   data : flattened bytes, requester i on data[i*DATA_BITS +: DATA_BITS].
//   ack  : one-clk pulse telling requester i that its byte was latched.
interface uart_tx_sched_if #(
    parameter int NREQ      = 4,
    parameter int DATA_BITS = 8
);
    logic [NREQ-1:0]           req;
    logic [NREQ*DATA_BITS-1:0] data;
    logic [NREQ-1:0]           ack;

    // Producer side drives requests and bytes, sees acknowledges.
    modport master (
        output req,
        output data,
        input  ack
    );

    // Scheduler side samples requests and bytes, returns acknowledges.
    modport slave (
        input  req,
        input  data,
        output ack
    );
endinterface

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler sharing one 8N1-style UART tx line
// between NREQ byte requesters. Bit timing comes from the 16x oversampled
// enable_16 tick; each bit lasts exactly 16 ticks. Requests are only sampled
// while idle, so back-to-back frames carry one extra idle-high clk.
// Optional even parity bit: define UART_TX_SCHED_PARITY_EN.
module uart_tx_sched #(
    parameter int NREQ      = 4,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable_16,
    uart_tx_sched_if.slave       bus,
    output logic [2:0]           grant_id,
    output logic                 busy,
    output logic                 tx
);

    // Bit counter must reach the larger of DATA_BITS-1 and STOP_BITS-1.
    localparam int CNT_MAX = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
    localparam int BCW     = $clog2(CNT_MAX) + 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_SCHED_PARITY_EN
        S_PARITY = 3'd4,
`endif
        S_STOP   = 3'd3
    } state_t;

    // Round-robin index: (base + off) mod NREQ, with base and off < NREQ.
    function automatic logic [2:0] rr_index(input logic [2:0] base, input logic [3:0] off);
        logic [3:0] sum;
        sum = {1'b0, base} + off;
        sum = (sum >= 4'(NREQ)) ? (sum - 4'(NREQ)) : sum;
        return sum[2:0];
    endfunction

`ifdef UART_TX_SCHED_PARITY_EN
    // Even parity over the latched character.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction
`endif

    // State and datapath registers
    state_t                 r_state;
    logic [3:0]             r_tick;
    logic [BCW-1:0]         r_bit;
    logic [DATA_BITS-1:0]   r_shift;
    logic [2:0]             r_ptr;
    logic [2:0]             r_grant;
    logic [NREQ-1:0]        r_ack;
    logic                   r_busy;
    logic                   r_tx;
`ifdef UART_TX_SCHED_PARITY_EN
    logic                   r_parity;
    logic                   w_parity_nxt;
`endif

    // Combinational next values
    state_t                 w_state_nxt;
    logic [3:0]             w_tick_nxt;
    logic [BCW-1:0]         w_bit_nxt;
    logic [DATA_BITS-1:0]   w_shift_nxt;
    logic [2:0]             w_ptr_nxt;
    logic [2:0]             w_grant_nxt;
    logic [NREQ-1:0]        w_ack_nxt;
    logic                   w_busy_nxt;
    logic                   w_tx_nxt;

    // Arbitration and timing helpers
    logic                   w_found;
    logic [2:0]             w_winner;
    logic [2:0]             w_idx;
    logic                   w_hit;
    logic [DATA_BITS-1:0]   w_data_sel;
    logic                   w_bit_end;
    logic                   w_last_data;
    logic                   w_last_stop;
    logic [3:0]             w_tick_inc;

    // A bit ends on the 16th tick; ticks outside a frame never matter
    // because IDLE ignores w_bit_end.
    assign w_bit_end   = enable_16 & (r_tick == 4'd15);
    assign w_last_data = (r_bit == BCW'(DATA_BITS - 1));
    assign w_last_stop = (r_bit == BCW'(STOP_BITS - 1));
    assign w_tick_inc  = enable_16 ? (r_tick + 4'd1) : r_tick;

    // Round-robin scan of req starting at r_ptr; first set bit wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = 3'd0;
        w_idx    = 3'd0;
        w_hit    = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            w_idx    = rr_index(r_ptr, 4'(i));
            w_hit    = |(bus.req & (NREQ'(1'b1) << w_idx));
            w_winner = (!w_found && w_hit) ? w_idx : w_winner;
            w_found  = w_found | w_hit;
        end
    end

    // Mux out the winner's character from the flattened data bus.
    always_comb begin
        w_data_sel = {DATA_BITS{1'b0}};
        for (int j = 0; j < NREQ; j++) begin
            w_data_sel = w_data_sel |
                         (bus.data[j*DATA_BITS +: DATA_BITS] & {DATA_BITS{(w_winner == 3'(j))}});
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: frame phases advance only at bit ends.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_START;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nxt = S_DATA;
                end else begin
                    w_state_nxt = S_START;
                end
            end
            S_DATA: begin
                if (w_bit_end && w_last_data) begin
`ifdef UART_TX_SCHED_PARITY_EN
                    w_state_nxt = S_PARITY;
`else
                    w_state_nxt = S_STOP;
`endif
                end else begin
                    w_state_nxt = S_DATA;
                end
            end
`ifdef UART_TX_SCHED_PARITY_EN
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = S_STOP;
                end else begin
                    w_state_nxt = S_PARITY;
                end
            end
`endif
            S_STOP: begin
                if (w_bit_end && w_last_stop) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_STOP;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM outputs: next values for the line, handshake and counters.
    always_comb begin
        w_tick_nxt  = r_tick;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_ptr_nxt   = r_ptr;
        w_grant_nxt = r_grant;
        w_ack_nxt   = {NREQ{1'b0}};
        w_busy_nxt  = r_busy;
        w_tx_nxt    = r_tx;
`ifdef UART_TX_SCHED_PARITY_EN
        w_parity_nxt = r_parity;
`endif
        case (r_state)
            S_IDLE: begin
                // A tick coinciding with acceptance is deliberately dropped:
                // the start bit counts from the next tick.
                if (w_found) begin
                    w_shift_nxt = w_data_sel;
                    w_ack_nxt   = NREQ'(1'b1) << w_winner;
                    w_grant_nxt = w_winner;
                    w_ptr_nxt   = rr_index(w_winner, 4'd1);
                    w_busy_nxt  = 1'b1;
                    w_tx_nxt    = 1'b0;
                    w_tick_nxt  = 4'd0;
                    w_bit_nxt   = {BCW{1'b0}};
`ifdef UART_TX_SCHED_PARITY_EN
                    w_parity_nxt = even_parity(w_data_sel);
`endif
                end else begin
                    w_busy_nxt = 1'b0;
                    w_tx_nxt   = 1'b1;
                    w_tick_nxt = 4'd0;
                end
            end
            S_START: begin
                w_tick_nxt = w_tick_inc;
                if (w_bit_end) begin
                    w_tx_nxt  = r_shift[0];
                    w_bit_nxt = {BCW{1'b0}};
                end else begin
                    w_tx_nxt = r_tx;
                end
            end
            S_DATA: begin
                w_tick_nxt = w_tick_inc;
                if (w_bit_end) begin
                    w_shift_nxt = r_shift >> 1;
                    if (w_last_data) begin
                        w_bit_nxt = {BCW{1'b0}};
`ifdef UART_TX_SCHED_PARITY_EN
                        w_tx_nxt  = r_parity;
`else
                        w_tx_nxt  = 1'b1;
`endif
                    end else begin
                        w_bit_nxt = r_bit + BCW'(1);
                        w_tx_nxt  = w_shift_nxt[0];
                    end
                end else begin
                    w_tx_nxt = r_tx;
                end
            end
`ifdef UART_TX_SCHED_PARITY_EN
            S_PARITY: begin
                w_tick_nxt = w_tick_inc;
                if (w_bit_end) begin
                    w_tx_nxt  = 1'b1;
                    w_bit_nxt = {BCW{1'b0}};
                end else begin
                    w_tx_nxt = r_tx;
                end
            end
`endif
            S_STOP: begin
                w_tick_nxt = w_tick_inc;
                w_tx_nxt   = 1'b1;
                if (w_bit_end) begin
                    if (w_last_stop) begin
                        w_busy_nxt = 1'b0;
                        w_bit_nxt  = {BCW{1'b0}};
                    end else begin
                        w_bit_nxt = r_bit + BCW'(1);
                    end
                end else begin
                    w_bit_nxt = r_bit;
                end
            end
            default: begin
                w_tick_nxt = 4'd0;
                w_bit_nxt  = {BCW{1'b0}};
                w_busy_nxt = 1'b0;
                w_tx_nxt   = 1'b1;
            end
        endcase
    end

    // Datapath and output registers; reset abandons any partial frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick  <= 4'd0;
            r_bit   <= {BCW{1'b0}};
            r_shift <= {DATA_BITS{1'b0}};
            r_ptr   <= 3'd0;
            r_grant <= 3'd0;
            r_ack   <= {NREQ{1'b0}};
            r_busy  <= 1'b0;
            r_tx    <= 1'b1;
`ifdef UART_TX_SCHED_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_tick  <= w_tick_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_ptr   <= w_ptr_nxt;
            r_grant <= w_grant_nxt;
            r_ack   <= w_ack_nxt;
            r_busy  <= w_busy_nxt;
            r_tx    <= w_tx_nxt;
`ifdef UART_TX_SCHED_PARITY_EN
            r_parity <= w_parity_nxt;
`endif
        end
    end

    assign bus.ack  = r_ack;
    assign grant_id = r_grant;
    assign busy     = r_busy;
    assign tx       = r_tx;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: self-checking bench for uart_tx_sched. A frame model
// gives the expected tx level from the count of enable_16 pulses since
// acceptance; a round-robin model predicts which requester wins.
module tb_uart_tx_sched;
    localparam int NREQ = 4;
    localparam int DB   = 8;
    localparam int SB   = 1;
`ifdef UART_TX_SCHED_PARITY_EN
    localparam int PAR  = 1;
`else
    localparam int PAR  = 0;
`endif
    localparam int NBITS = 1 + DB + PAR + SB;
    localparam int TOTAL = NBITS * 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable_16;
    logic [2:0] grant_id;
    logic       busy;
    logic       tx;

    uart_tx_sched_if #(.NREQ(NREQ), .DATA_BITS(DB)) bus_if();

    uart_tx_sched #(.NREQ(NREQ), .DATA_BITS(DB), .STOP_BITS(SB)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable_16 (enable_16),
        .bus       (bus_if),
        .grant_id  (grant_id),
        .busy      (busy),
        .tx        (tx)
    );

    always #5 clk = ~clk;

    int              vectors     = 0;
    int              miscompares = 0;
    int              en_period   = 1;
    int              en_phase    = 0;
    logic            en_at_edge;
    logic [NREQ-1:0] req_at_edge;
    int              m_ptr       = 0;
    logic [DB-1:0]   tb_byte [NREQ];

    // Advance one clock; remember what the DUT saw at that edge.
    task automatic step();
        en_at_edge  = enable_16;
        req_at_edge = bus_if.req;
        @(posedge clk);
        #1;
        if (en_period < 0) begin
            enable_16 = ($urandom_range(0, 2) == 0);
        end else begin
            enable_16 = (en_phase == 0);
            en_phase  = (en_phase + 1) % en_period;
        end
    endtask

    // period 1 = tied high, N = one pulse every N clk, negative = random.
    task automatic set_en(input int period);
        en_period = period;
        if (period < 0) begin
            enable_16 = ($urandom_range(0, 2) == 0);
            en_phase  = 0;
        end else begin
            enable_16 = 1'b1;
            en_phase  = 1 % period;
        end
    endtask

    task automatic set_byte(input int i, input logic [DB-1:0] b);
        tb_byte[i] = b;
        bus_if.data[i*DB +: DB] = b;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        bus_if.req = '0;
        for (int k = 0; k < n; k++) step();
        rst = 1'b0;
        m_ptr = 0;
    endtask

    function automatic int model_pick(input logic [NREQ-1:0] r, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    // Line level for bit slot idx of a frame carrying byte b.
    function automatic logic exp_level(input logic [DB-1:0] b, input int idx);
        if (idx == 0) return 1'b0;
        else if (idx <= DB) return b[idx-1];
        else if (PAR == 1 && idx == DB + 1) return ^b;
        else return 1'b1;
    endfunction

    // Follow a frame cycle by cycle from pulse count p0 to its end.
    task automatic check_frame(input int exp_id, input logic [DB-1:0] b, input int p0, output int steps);
        int  p;
        int  n;
        bit  done;
        logic want;
        p = p0; n = 0; done = 0;
        while (!done) begin
            step();
            n++;
            if (en_at_edge) p++;
            vectors++;
            if (p >= TOTAL) begin
                if (busy !== 1'b0 || tx !== 1'b1 || bus_if.ack !== '0) begin
                    $display("FAIL frame_end id=%0d: busy=%b tx=%b ack=%b, want busy=0 tx=1 ack=0",
                             exp_id, busy, tx, bus_if.ack);
                    miscompares++;
                end
                done = 1;
            end else if (n > TOTAL * 12 + 100) begin
                $display("FAIL frame_timeout id=%0d: pulses=%0d after %0d clk, want %0d", exp_id, p, n, TOTAL);
                miscompares++;
                done = 1;
            end else begin
                want = exp_level(b, p / 16);
                if (tx !== want || busy !== 1'b1 || bus_if.ack !== '0 || grant_id !== 3'(exp_id)) begin
                    $display("FAIL frame_bit id=%0d pulse=%0d: tx=%b busy=%b ack=%b gid=%0d, want tx=%b busy=1 ack=0 gid=%0d",
                             exp_id, p, tx, busy, bus_if.ack, grant_id, want, exp_id);
                    miscompares++;
                end
            end
        end
        steps = n;
    endtask

    // Wait for an ack, check it against the round-robin model, optionally run the frame.
    task automatic accept_frame(input int max_wait, input int exact_wait, input bit drop, input bit run,
                                output int got_id, output int steps);
        int n;
        bit seen;
        int exp;
        n = 0; seen = 0; got_id = -1; steps = 0;
        while (!seen && n < max_wait) begin
            step();
            n++;
            if (bus_if.ack !== '0) seen = 1;
        end
        vectors++;
        if (!seen) begin
            $display("FAIL accept_timeout: no ack within %0d clk, req=%b", max_wait, bus_if.req);
            miscompares++;
            return;
        end
        exp = model_pick(req_at_edge, m_ptr);
        if (exp < 0) begin
            $display("FAIL spurious_ack: ack=%b with req=%b, want no ack", bus_if.ack, req_at_edge);
            miscompares++;
            return;
        end
        got_id = int'(grant_id);
        if (bus_if.ack !== (NREQ'(1) << exp) || grant_id !== 3'(exp) || busy !== 1'b1 || tx !== 1'b0) begin
            $display("FAIL accept: ack=%b gid=%0d busy=%b tx=%b, want ack=%b gid=%0d busy=1 tx=0",
                     bus_if.ack, grant_id, busy, tx, NREQ'(1) << exp, exp);
            miscompares++;
        end
        if (exact_wait > 0) begin
            vectors++;
            if (n !== exact_wait) begin
                $display("FAIL ack_latency: ack after %0d clk, want %0d", n, exact_wait);
                miscompares++;
            end
        end
        m_ptr = (exp + 1) % NREQ;
        if (drop) bus_if.req[exp] = 1'b0;
        if (run) check_frame(exp, tb_byte[exp], 0, steps);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_if.req = '1;
        for (int k = 0; k < 3; k++) begin
            step();
            vectors++;
            if (tx !== 1'b1 || busy !== 1'b0 || bus_if.ack !== '0 || grant_id !== 3'd0) begin
                $display("FAIL reset_state: tx=%b busy=%b ack=%b gid=%0d, want tx=1 busy=0 ack=0 gid=0",
                         tx, busy, bus_if.ack, grant_id);
                miscompares++;
            end
        end
        bus_if.req = '0;
        rst = 1'b0;
        m_ptr = 0;
    endtask

    task automatic test_single_frame();
        int id, st;
        do_reset(2);
        set_en(1);
        set_byte(0, 8'hA5);
        bus_if.req = 4'b0001;
        accept_frame(4, 1, 1, 1, id, st);
        vectors++;
        if (st !== TOTAL) begin
            $display("FAIL frame_length: busy fell %0d clk after accept, want %0d", st, TOTAL);
            miscompares++;
        end
    endtask

    task automatic test_round_robin();
        int id, st;
        do_reset(2);
        set_en(1);
        set_byte(0, 8'h11); set_byte(1, 8'h22); set_byte(2, 8'h33); set_byte(3, 8'h44);
        bus_if.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            accept_frame(4, 1, 0, 1, id, st);
            vectors++;
            if (id !== k % NREQ) begin
                $display("FAIL rr_order frame %0d: granted %0d, want %0d", k, id, k % NREQ);
                miscompares++;
            end
        end
        bus_if.req = '0;
    endtask

    task automatic test_slow_baud();
        int id, st, r;
        set_en(5);
        for (int k = 0; k < 2; k++) begin
            r = $urandom_range(0, NREQ - 1);
            set_byte(r, DB'($urandom));
            bus_if.req[r] = 1'b1;
            accept_frame(4, 1, 1, 1, id, st);
        end
    endtask

    task automatic test_reset_mid_frame();
        int id, st;
        do_reset(2);
        set_en(1);
        set_byte(1, DB'($urandom));
        set_byte(2, DB'($urandom));
        bus_if.req = 4'b0100;
        accept_frame(4, 1, 0, 0, id, st);
        for (int k = 0; k < 70; k++) step();
        rst = 1'b1;
        bus_if.req = '0;
        step();
        vectors++;
        if (tx !== 1'b1 || busy !== 1'b0 || bus_if.ack !== '0 || grant_id !== 3'd0) begin
            $display("FAIL mid_reset: tx=%b busy=%b ack=%b gid=%0d, want tx=1 busy=0 ack=0 gid=0",
                     tx, busy, bus_if.ack, grant_id);
            miscompares++;
        end
        rst = 1'b0;
        m_ptr = 0;
        bus_if.req = 4'b0110;
        accept_frame(4, 1, 1, 1, id, st);
        vectors++;
        if (id !== 1) begin
            $display("FAIL post_reset_grant: granted %0d, want 1", id);
            miscompares++;
        end
        accept_frame(4, 1, 1, 1, id, st);
    endtask

    task automatic test_req_glitch();
        int id, st, p;
        set_en(1);
        set_byte(0, DB'($urandom));
        bus_if.req = 4'b0001;
        accept_frame(4, 1, 1, 0, id, st);
        p = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (en_at_edge) p++;
        end
        bus_if.req[1] = 1'b1;
        step();
        if (en_at_edge) p++;
        bus_if.req[1] = 1'b0;
        check_frame(0, tb_byte[0], p, st);
        for (int k = 0; k < 40; k++) begin
            step();
            vectors++;
            if (bus_if.ack !== '0 || busy !== 1'b0 || tx !== 1'b1) begin
                $display("FAIL glitch_idle: ack=%b busy=%b tx=%b, want ack=0 busy=0 tx=1", bus_if.ack, busy, tx);
                miscompares++;
            end
        end
    endtask

    task automatic test_random();
        int id, st;
        set_en(-1);
        for (int f = 0; f < 12; f++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!bus_if.req[i] && $urandom_range(0, 1) == 1) begin
                    set_byte(i, DB'($urandom));
                    bus_if.req[i] = 1'b1;
                end
            end
            if (bus_if.req == '0) begin
                set_byte(f % NREQ, DB'($urandom));
                bus_if.req[f % NREQ] = 1'b1;
            end
            accept_frame(4, 1, 1, 1, id, st);
        end
        bus_if.req = '0;
    endtask

    task automatic test_parity();
        int id, st;
        set_en(1);
        set_byte(3, 8'h07);
        bus_if.req = 4'b1000;
        accept_frame(4, 1, 1, 1, id, st);
        vectors++;
        if (st !== TOTAL) begin
            $display("FAIL parity_frame_length: %0d clk, want %0d", st, TOTAL);
            miscompares++;
        end
    endtask

    initial begin
        rst         = 1'b1;
        enable_16   = 1'b0;
        bus_if.req  = '0;
        bus_if.data = '0;
        for (int i = 0; i < NREQ; i++) tb_byte[i] = '0;
        test_reset();
        test_single_frame();
        test_round_robin();
        test_slow_baud();
        test_reset_mid_frame();
        test_req_glitch();
        test_random();
        test_parity();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Shares one 8N1-style UART transmit line between NREQ byte requesters, using round-robin arbitration.
- Serialises the granted byte, timed by the 16x-oversampled enable_16 tick from the team's DDS baud clock generator.
- Sits between the per-channel debug/status producers and the physical tx pin. The baud generator stays free-running; this block is its only consumer.

Parameters:
- NREQ, 4, number of requesters (1..8).
- DATA_BITS, 8, bits per character, sent LSB first.
- STOP_BITS, 1, stop bits per frame (1 or 2).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- enable_16  input  1  one-clk pulse at 16x baud rate, from the DDS baud clock.
- req  input  NREQ  per-requester byte-valid. Held high until the matching ack.
- data  input  NREQ*DATA_BITS  flattened bytes. Requester i uses data[i*DATA_BITS +: DATA_BITS].
- ack  output  NREQ  one-clk pulse: byte of requester i latched.
- grant_id  output  3  index of the requester currently being transmitted.
- busy  output  1  high whenever a frame is in progress.
- tx  output  1  serial line, idle high.

Behaviour:
- Reset values: tx=1, busy=0, ack=0, grant_id=0, state=IDLE, tick counter=0, bit counter=0, round-robin pointer=0 (requester 0 has highest priority first).
- FSM states: IDLE, START, DATA, PARITY (only with the optional feature), STOP.
- IDLE:
  - Each clk, scan req starting at index ptr, wrapping modulo NREQ. The first set bit wins.
  - The winner's data is latched into the shift register. ack[winner] pulses high on the next clk edge, so registered ack is high exactly one cycle.
  - On that same edge: grant_id=winner, ptr=winner+1 mod NREQ, busy=1, state=START, tx=0, tick counter=0.
  - Arbitration does not depend on enable_16.
- Bit timing:
  - Each bit lasts exactly 16 enable_16 pulses.
  - The tick counter (4 bits) increments only on enable_16. At count 15 plus enable_16, it wraps to 0 and the bit ends.
  - tx changes only at bit ends, except the START entry edge.
  - Clk cycles without enable_16 hold all state.
- START end: state=DATA, tx=shift[0], bit counter=0.
- DATA:
  - At each bit end, shift right. tx takes the next bit.
  - After DATA_BITS bits: go to PARITY if enabled, else STOP with tx=1.
- STOP:
  - Lasts STOP_BITS*16 enable_16 pulses with tx=1.
  - At its end: state=IDLE, busy=0.
  - The earliest next arbitration is the following clk. Back-to-back frames are therefore separated by exactly one clk of idle-high in addition to the stop bits.
- Requests:
  - req changes during a frame are ignored; requests are sampled only in IDLE.
  - If req drops before ack, nothing is sent and there is no ack.
  - data must be stable while req is high. The block samples it only on the accepting cycle.
- Simultaneous events:
  - Requests arriving in the same IDLE cycle go to round-robin order.
  - An enable_16 pulse coinciding with acceptance does not count toward the start bit; counting begins with the next pulse.
- Reset mid-frame: on the next edge tx=1 and busy=0, and all counters and ptr return to their reset values. The partial frame is abandoned and no ack is re-issued.
- Unused grant_id upper bits are 0.
- Frame length without parity: (1+DATA_BITS+STOP_BITS)*16 enable_16 pulses, which is 160 for the defaults.

Optional Feature:
- Macro: UART_TX_SCHED_PARITY_EN.
- Defined:
  - PARITY state is inserted after DATA and lasts 16 enable_16 pulses.
  - tx = XOR of the latched data bits (even parity).
  - Frame length is 176 pulses for the defaults.
- Undefined: no PARITY state, no parity logic, DATA goes directly to STOP.

Test Plan:
- enable_16 tied to 1, req=4'b0001, data0=8'hA5.
  - ack[0] pulses once, one clk after req.
  - tx sequence is 0,1,0,1,0,0,1,0,1,1, each level held 16 clk.
  - busy falls 160 clk after acceptance.
- req=4'b1111 held continuously with distinct data (8'h11, 8'h22, 8'h33, 8'h44).
  - Grant order is 0,1,2,3,0.
  - Each ack occurs one clk after the previous frame's busy falls.
- enable_16 = 1 clk in 5 (DDS model, baudrate=12500, TOP=62500).
  - Each bit lasts 80 clk ±0.
  - All outputs hold between pulses.
- rst asserted during DATA bit 3 of a frame from requester 2.
  - Next edge: tx=1, busy=0.
  - After rst drops with req=4'b0110, requester 1 is granted first (ptr reset to 0).
- req[1] pulsed high 1 clk while busy, then dropped.
  - No ack[1] and no extra frame after the current one.
- With UART_TX_SCHED_PARITY_EN and data=8'h07: parity bit is 1, and the frame lasts 176 clk with enable_16 tied to 1.
